crc_check_scheduler: RTL and testbench
======================================

Name: crc_check_scheduler

Overview:
- Shares one bit-serial CRC-8 checker engine (poly 0x07, init 0x00, MSB first) between NUM_REQ byte-stream requesters.
- Round-robin arbiter grants one requester per frame, streams its bytes through the engine, and reports a per-frame pass/fail result tagged with the requester id.
- A frame is payload bytes followed by its CRC byte; the last byte is flagged with s_last.
- Sits between the link-side receive channels and the frame-status logic.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester id, equal to clog2(NUM_REQ).
- MAX_BYTES, 64, maximum bytes per frame including the CRC byte.
- CNT_W, 7, byte-counter width, enough to hold MAX_BYTES.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-requester frame request
- s_data  in  NUM_REQ*8  packed bytes; requester i on bits [8i+7:8i]
- s_valid  in  NUM_REQ  byte valid per requester
- s_last  in  NUM_REQ  final (CRC) byte of frame
- s_ready  out  NUM_REQ  byte accepted when s_valid&s_ready
- gnt  out  NUM_REQ  one-hot current owner, 0 when idle
- busy  out  1  frame in progress
- res_valid  out  1  one-cycle result pulse
- res_id  out  ID_W  requester that owned the frame
- res_error  out  1  nonzero remainder or length error
- res_len_err  out  1  frame exceeded MAX_BYTES
- res_count  out  CNT_W  bytes processed in frame

Behaviour:
- Reset: all outputs 0; state IDLE; rr pointer 0; CRC 0x00; counters 0.
- States:
  - IDLE: if any req bit is set, pick the first set bit at or after the rr pointer (wrapping); register gnt, clear CRC and byte count; go RECV. Grant is visible the cycle after req is sampled.
  - RECV: s_ready[g]=1, all other ready bits 0. On s_valid[g], latch the byte and s_last[g], increment the byte count, go SHIFT. Stay in RECV without timeout while valid is low.
  - SHIFT: 8 cycles, bit 7 first. Each cycle: crc = {crc[6:0],0} ^ (crc[7] ? 0x07 : 0) ^ bit. After the 8th bit:
    - if last: go REPORT.
    - else if count==MAX_BYTES: go REPORT with the length error set.
    - else: go RECV.
  - REPORT: one cycle. Drive res_valid=1, res_id=g, res_count, res_len_err, res_error=(crc!=0)|len_err. Set rr pointer = g+1 mod NUM_REQ, drop gnt, go IDLE.
- Throughput: 9 cycles per byte minimum (1 accept + 8 shift). Frame overhead: 1 cycle arbitration + 1 cycle report.
- A requester holding req over multiple frames gets at most one frame before the others are served (rr fairness).
- Deassertion of req after grant is ignored; only s_last or the length limit terminates a frame.
- Bytes following a length abort are treated by the bench as a new frame from that requester after re-arbitration.
- s_ready is 0 in IDLE, SHIFT and REPORT. s_valid/s_data from non-granted requesters are ignored.
- res_* hold their value until the next REPORT; res_valid is a pulse.
- busy=1 in RECV, SHIFT and REPORT.
- Reset asserted mid-frame: immediate return to reset values; no res_valid is emitted.

Decomposition:
- Shared package: CRC8_POLY=8'h07, CRC8_INIT=8'h00, state encoding (IDLE, RECV, SHIFT, REPORT).
- Sub-module crc8_serial_engine: clear, shift_en and bit_in inputs; crc[7:0] output; one bit per cycle. It holds the CRC register and is reused by the standalone frame checker.
- The round-robin priority picker stays inline.

Test Plan:
- Req[0] sends frame {0x01, 0x07} -> gnt=0001; after 2×9+2 cycles res_valid with res_id=0, res_error=0, res_count=2.
- Req[2] sends {0x01, 0x06} -> res_error=1, res_len_err=0, res_id=2.
- Req[1] sends "123456789" (0x31..0x39) then 0xF4 -> res_error=0, res_count=10.
- All four req held high, each sending {0x00, 0x00} repeatedly -> grant order 0,1,2,3,0; no requester served twice in a row.
- Req[3] sends 64 bytes with s_last never set -> after the 64th byte: res_valid, res_len_err=1, res_error=1, res_count=64.
- rst_n pulsed low during SHIFT of byte 2 -> gnt, s_ready, busy go 0 asynchronously; no res_valid; a subsequent frame is checked correctly.

Source files
------------

// File: rtl/crc_check_scheduler_pkg.sv
// Shared definitions for the CRC-8 check scheduler: polynomial, init value,
// FSM encoding and the single-bit CRC update.
package crc_check_scheduler_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    SHIFT  = 2'd2,
    REPORT = 2'd3
  } state_t;

  // One MSB-first step; feeding payload then its CRC byte leaves a zero remainder.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    return {crc[6:0], 1'b0} ^ (crc[7] ? CRC8_POLY : 8'h00) ^ {7'b0, bit_in};
  endfunction

endpackage

// File: rtl/crc_check_scheduler_engine.sv
// Bit-serial CRC-8 register: one message bit per enabled cycle, synchronous clear.
module crc8_serial_engine
  import crc_check_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC8_INIT;
    end else if (clear) begin
      crc <= CRC8_INIT;
    end else if (shift_en) begin
      crc <= crc8_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/crc_check_scheduler.sv
// Round-robin scheduler sharing one serial CRC-8 checker among NUM_REQ byte
// streams; one frame per grant, result reported with the owner's id.
module crc_check_scheduler
  import crc_check_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned MAX_BYTES = 64,
  parameter int unsigned CNT_W     = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*BYTE_W-1:0] s_data,
  input  logic [NUM_REQ-1:0]        s_valid,
  input  logic [NUM_REQ-1:0]        s_last,
  output logic [NUM_REQ-1:0]        s_ready,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      busy,
  output logic                      res_valid,
  output logic [ID_W-1:0]           res_id,
  output logic                      res_error,
  output logic                      res_len_err,
  output logic [CNT_W-1:0]          res_count
);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic [ID_W-1:0]      owner_q, owner_d;
  logic [ID_W-1:0]      rr_q, rr_d;
  logic [7:0]           byte_q, byte_d;
  logic                 last_q, last_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [2:0]           bit_q, bit_d;
  logic                 len_err_q, len_err_d;
  logic                 busy_q, busy_d;
  logic                 res_valid_q, res_valid_d;
  logic [ID_W-1:0]      res_id_q, res_id_d;
  logic                 res_error_q, res_error_d;
  logic                 res_len_err_q, res_len_err_d;
  logic [CNT_W-1:0]     res_count_q, res_count_d;

  logic                 crc_clear, crc_shift;
  logic [7:0]           crc;
  logic                 pick_found;
  logic [ID_W-1:0]      pick_id;
  int unsigned          idx;
  logic [7:0]           data_arr [NUM_REQ];
  logic [7:0]           sel_byte;
  logic                 sel_last;
  logic                 accept;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = s_data[BYTE_W*gi +: BYTE_W];
  end

  assign sel_byte = data_arr[owner_q];
  assign sel_last = s_last[owner_q];
  assign accept   = s_valid[owner_q] & ready_q[owner_q];

  crc8_serial_engine u_engine (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (crc_clear),
    .shift_en (crc_shift),
    .bit_in   (byte_q[7]),
    .crc      (crc)
  );

  // Round-robin pick: first requesting index at or after rr_q, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(rr_q) + i) % NUM_REQ;
      if (!pick_found && req[ID_W'(idx)]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the next value of every registered output and datapath reg.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    ready_d       = '0;
    owner_d       = owner_q;
    rr_d          = rr_q;
    byte_d        = byte_q;
    last_d        = last_q;
    count_d       = count_q;
    bit_d         = bit_q;
    len_err_d     = len_err_q;
    res_valid_d   = 1'b0;
    res_id_d      = res_id_q;
    res_error_d   = res_error_q;
    res_len_err_d = res_len_err_q;
    res_count_d   = res_count_q;
    crc_clear     = 1'b0;
    crc_shift     = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d   = RECV;
          gnt_d     = NUM_REQ'(1) << pick_id;
          ready_d   = NUM_REQ'(1) << pick_id;
          owner_d   = pick_id;
          count_d   = '0;
          len_err_d = 1'b0;
          crc_clear = 1'b1;
        end
      end
      RECV: begin
        ready_d = gnt_q;
        if (accept) begin
          state_d = SHIFT;
          ready_d = '0;
          byte_d  = sel_byte;
          last_d  = sel_last;
          count_d = CNT_W'(count_q + 1'b1);
          bit_d   = 3'd0;
        end
      end
      SHIFT: begin
        crc_shift = 1'b1;
        byte_d    = {byte_q[6:0], 1'b0};
        bit_d     = 3'(bit_q + 3'd1);
        if (bit_q == 3'd7) begin
          if (last_q) begin
            state_d = REPORT;
          end else if (count_q == CNT_W'(MAX_BYTES)) begin
            state_d   = REPORT;
            len_err_d = 1'b1;
          end else begin
            state_d = RECV;
            ready_d = gnt_q;
          end
        end
      end
      REPORT: begin
        state_d       = IDLE;
        gnt_d         = '0;
        res_valid_d   = 1'b1;
        res_id_d      = owner_q;
        res_count_d   = count_q;
        res_len_err_d = len_err_q;
        res_error_d   = (crc != 8'h00) | len_err_q;
        rr_d          = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : ID_W'(owner_q + 1'b1);
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q         <= '0;
      ready_q       <= '0;
      owner_q       <= '0;
      rr_q          <= '0;
      byte_q        <= '0;
      last_q        <= 1'b0;
      count_q       <= '0;
      bit_q         <= '0;
      len_err_q     <= 1'b0;
      busy_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      res_id_q      <= '0;
      res_error_q   <= 1'b0;
      res_len_err_q <= 1'b0;
      res_count_q   <= '0;
    end else begin
      gnt_q         <= gnt_d;
      ready_q       <= ready_d;
      owner_q       <= owner_d;
      rr_q          <= rr_d;
      byte_q        <= byte_d;
      last_q        <= last_d;
      count_q       <= count_d;
      bit_q         <= bit_d;
      len_err_q     <= len_err_d;
      busy_q        <= busy_d;
      res_valid_q   <= res_valid_d;
      res_id_q      <= res_id_d;
      res_error_q   <= res_error_d;
      res_len_err_q <= res_len_err_d;
      res_count_q   <= res_count_d;
    end
  end

  assign gnt         = gnt_q;
  assign s_ready     = ready_q;
  assign busy        = busy_q;
  assign res_valid   = res_valid_q;
  assign res_id      = res_id_q;
  assign res_error   = res_error_q;
  assign res_len_err = res_len_err_q;
  assign res_count   = res_count_q;

endmodule

// File: tb/tb_crc_check_scheduler.sv
// Directed self-checking bench for crc_check_scheduler: CRC pass/fail frames,
// round-robin order, length abort and mid-frame reset.
module tb_crc_check_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, s_valid, s_last, s_ready, gnt;
  logic [31:0] s_data;
  logic        busy, res_valid, res_error, res_len_err;
  logic [1:0]  res_id;
  logic [6:0]  res_count;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  logic [7:0] fbuf [64];

  crc_check_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .gnt         (gnt),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_id      (res_id),
    .res_error   (res_error),
    .res_len_err (res_len_err),
    .res_count   (res_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one byte on requester r and hold it until the accepting edge.
  task automatic send_byte(input int r, input logic [7:0] b, input logic last);
    int waited;
    waited = 0;
    s_data[8*r +: 8] = b;
    s_last[r]        = last;
    s_valid[r]       = 1'b1;
    while (!s_ready[r] && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    s_valid[r] = 1'b0;
    s_last[r]  = 1'b0;
  endtask

  task automatic wait_res(output int at_cyc);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!res_valid && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) check("res_timeout", 32'd0, 32'd1);
    at_cyc = cyc;
  endtask

  // Request, stream n bytes from fbuf, drop req once the frame has started.
  task automatic run_frame(input int r, input int n, input logic use_last);
    req[r] = 1'b1;
    for (int k = 0; k < n; k++) begin
      send_byte(r, fbuf[k], use_last && (k == n - 1));
      if (k == 0) req[r] = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, r, prev, waited;
    logic seen;

    rst_n = 1'b0; req = '0; s_valid = '0; s_last = '0; s_data = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_ready", 32'(s_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_res_valid", 32'(res_valid), 32'h0);
    check("rst_res_id", 32'(res_id), 32'h0);
    check("rst_res_error", 32'(res_error), 32'h0);
    check("rst_res_len_err", 32'(res_len_err), 32'h0);
    check("rst_res_count", 32'(res_count), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Frame {0x01, 0x07} from requester 0: good CRC, 20-cycle latency.
    t0 = cyc;
    req[0] = 1'b1;
    @(negedge clk);
    check("f1_gnt", 32'(gnt), 32'h1);
    check("f1_busy", 32'(busy), 32'h1);
    check("f1_ready", 32'(s_ready), 32'h1);
    send_byte(0, 8'h01, 1'b0);
    req[0] = 1'b0;
    send_byte(0, 8'h07, 1'b1);
    wait_res(t1);
    check("f1_latency", 32'(t1 - t0), 32'd20);
    check("f1_id", 32'(res_id), 32'd0);
    check("f1_error", 32'(res_error), 32'd0);
    check("f1_len_err", 32'(res_len_err), 32'd0);
    check("f1_count", 32'(res_count), 32'd2);
    @(negedge clk);
    check("f1_pulse", 32'(res_valid), 32'd0);
    check("f1_hold_count", 32'(res_count), 32'd2);
    check("f1_idle_gnt", 32'(gnt), 32'h0);
    check("f1_idle_busy", 32'(busy), 32'h0);

    // Frame {0x01, 0x06} from requester 2: bad CRC.
    fbuf[0] = 8'h01; fbuf[1] = 8'h06;
    run_frame(2, 2, 1'b1);
    wait_res(t1);
    check("f2_id", 32'(res_id), 32'd2);
    check("f2_error", 32'(res_error), 32'd1);
    check("f2_len_err", 32'(res_len_err), 32'd0);
    check("f2_count", 32'(res_count), 32'd2);

    // "123456789" + 0xF4 from requester 1: good CRC.
    for (int k = 0; k < 9; k++) fbuf[k] = 8'(8'h31 + k);
    fbuf[9] = 8'hF4;
    run_frame(1, 10, 1'b1);
    wait_res(t1);
    check("f3_id", 32'(res_id), 32'd1);
    check("f3_error", 32'(res_error), 32'd0);
    check("f3_count", 32'(res_count), 32'd10);

    // Reset pulse returns the round-robin pointer to 0.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // All requesters held: grants rotate 0,1,2,3,0.
    req  = 4'hF;
    prev = -1;
    for (int k = 0; k < 5; k++) begin
      waited = 0;
      while (gnt == 4'h0 && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 50) check("rr_gnt_timeout", 32'd0, 32'd1);
      check("rr_onehot", 32'($onehot(gnt)), 32'd1);
      r = 0;
      for (int i = 0; i < 4; i++) if (gnt[i]) r = i;
      check("rr_order", 32'(r), 32'(k % 4));
      check("rr_no_repeat", 32'(r == prev), 32'd0);
      prev = r;
      send_byte(r, 8'h00, 1'b0);
      send_byte(r, 8'h00, 1'b1);
      if (k == 4) req = 4'h0;
      wait_res(t1);
      check("rr_res_id", 32'(res_id), 32'(k % 4));
      check("rr_res_error", 32'(res_error), 32'd0);
    end

    // 64 bytes from requester 3 without s_last: length abort.
    for (int k = 0; k < 64; k++) fbuf[k] = 8'(k);
    run_frame(3, 64, 1'b0);
    wait_res(t1);
    check("len_id", 32'(res_id), 32'd3);
    check("len_len_err", 32'(res_len_err), 32'd1);
    check("len_error", 32'(res_error), 32'd1);
    check("len_count", 32'(res_count), 32'd64);

    // Reset in the middle of shifting byte 2.
    req[0] = 1'b1;
    send_byte(0, 8'h01, 1'b0);
    req[0] = 1'b0;
    send_byte(0, 8'h07, 1'b1);
    @(posedge clk);
    #2;
    check("mr_pre_gnt", 32'(gnt), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mr_gnt", 32'(gnt), 32'h0);
    check("mr_ready", 32'(s_ready), 32'h0);
    check("mr_busy", 32'(busy), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    check("mr_no_res", 32'(seen), 32'd0);
    fbuf[0] = 8'h01; fbuf[1] = 8'h07;
    run_frame(0, 2, 1'b1);
    wait_res(t1);
    check("mr_after_id", 32'(res_id), 32'd0);
    check("mr_after_error", 32'(res_error), 32'd0);
    check("mr_after_count", 32'(res_count), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
